// File: rtl/pif_xi_if.sv
// XI strobe bus between the I2C/wishbone front end (master) and the register bank (slave).
// xo carries the registered read byte back to the front end.
interface pif_xi_if #(
  parameter int XA_BITS   = 4,
  parameter int DATA_BITS = 6,
  parameter int SUBA_BITS = 3
);
  logic                 xi_pwr;
  logic [XA_BITS-1:0]   xi_prwa;
  logic                 xi_prdfinished;
  logic [SUBA_BITS-1:0] xi_prdsuba;
  logic [DATA_BITS-1:0] xi_pd;
  logic [7:0]           xo;

  modport master (
    output xi_pwr, xi_prwa, xi_prdfinished, xi_prdsuba, xi_pd,
    input  xo
  );

  modport slave (
    input  xi_pwr, xi_prwa, xi_prdfinished, xi_prdsuba, xi_pd,
    output xo
  );
endinterface

// File: rtl/pif_xi_regbank.sv
// Register bank behind the XI strobes: ID string, scratch, LED, tick snapshot and
// write-strobe counter, with a one-clock registered read mux onto xo.
module pif_xi_regbank #(
  parameter int          XA_BITS   = 4,
  parameter int          DATA_BITS = 6,
  parameter int          SUBA_BITS = 3,
  parameter logic [63:0] ID_STRING = 64'h5049_4620_7631_2E30
) (
  input  logic                   xclk,
  input  logic                   rst,
  pif_xi_if.slave                xi,
  output logic [DATA_BITS-1:0]   led_o,
  output logic [2*DATA_BITS-1:0] scratch_o
);

  localparam logic [XA_BITS-1:0]   ADDR_ID      = XA_BITS'(0);
  localparam logic [XA_BITS-1:0]   ADDR_SCRATCH = XA_BITS'(1);
  localparam logic [XA_BITS-1:0]   ADDR_LED     = XA_BITS'(2);
  localparam logic [XA_BITS-1:0]   ADDR_TICK    = XA_BITS'(3);
  localparam logic [XA_BITS-1:0]   ADDR_WRCOUNT = XA_BITS'(4);
  localparam logic [SUBA_BITS-1:0] SUB0         = SUBA_BITS'(0);
  localparam logic [SUBA_BITS-1:0] SUB1         = SUBA_BITS'(1);
  localparam logic [SUBA_BITS-1:0] SUB2         = SUBA_BITS'(2);
  localparam logic [SUBA_BITS-1:0] SUB_MAX      = {SUBA_BITS{1'b1}};

  logic [XA_BITS-1:0]   prevAddr;
  logic [SUBA_BITS-1:0] wsub;
  logic [SUBA_BITS-1:0] wsubNext;
  logic [SUBA_BITS-1:0] effSub;
  logic                 addrChange;
  logic [DATA_BITS-1:0] stage;
  logic [23:0]          tick;
  logic [23:0]          snap;
  logic [7:0]           wrCount;
  logic [7:0]           wrCountNext;
  logic                 wrClear;
  logic [7:0]           xoReg;
  logic [7:0]           xoNext;
  logic [63:0]          idShifted;
  logic [15:0]          scratchWide;

  // Sub-index: a write on a fresh address always lands on sub 0, then walks up
  // and sticks at the top sub so runaway bursts cannot wrap onto sub 0.
  always_comb begin
    addrChange = (xi.xi_prwa != prevAddr);
    effSub     = addrChange ? SUB0 : wsub;
    wsubNext   = wsub;
    if (xi.xi_pwr) begin
      if (addrChange) begin
        wsubNext = SUB1;
      end else if (wsub != SUB_MAX) begin
        wsubNext = wsub + SUBA_BITS'(1);
      end
    end else if (addrChange) begin
      wsubNext = SUB0;
    end
  end

  // Read-clear wins over counting, but a coincident strobe is still counted once.
  always_comb begin
    wrClear     = xi.xi_prdfinished && (xi.xi_prwa == ADDR_WRCOUNT) && (xi.xi_prdsuba == SUB0);
    wrCountNext = wrCount;
    if (wrClear) begin
      wrCountNext = xi.xi_pwr ? 8'h01 : 8'h00;
    end else if (xi.xi_pwr && (wrCount != 8'hFF)) begin
      wrCountNext = wrCount + 8'h01;
    end
  end

  always_comb begin
    idShifted   = ID_STRING << {xi.xi_prdsuba, 3'b000};
    scratchWide = 16'(scratch_o);
    xoNext      = 8'h00;
    case (xi.xi_prwa)
      ADDR_ID: begin
        xoNext = idShifted[63:56];
      end
      ADDR_SCRATCH: begin
        if (xi.xi_prdsuba == SUB0) begin
          xoNext = scratchWide[15:8];
        end else if (xi.xi_prdsuba == SUB1) begin
          xoNext = scratchWide[7:0];
        end
      end
      ADDR_LED: begin
        if (xi.xi_prdsuba == SUB0) begin
          xoNext = 8'(led_o);
        end
      end
      ADDR_TICK: begin
        if (xi.xi_prdsuba == SUB0) begin
          xoNext = snap[23:16];
        end else if (xi.xi_prdsuba == SUB1) begin
          xoNext = snap[15:8];
        end else if (xi.xi_prdsuba == SUB2) begin
          xoNext = snap[7:0];
        end
      end
      ADDR_WRCOUNT: begin
        if (xi.xi_prdsuba == SUB0) begin
          xoNext = wrCount;
        end
      end
      default: begin
        xoNext = 8'h00;
      end
    endcase
  end

  always_ff @(posedge xclk) begin
    if (rst) begin
      prevAddr  <= '0;
      wsub      <= '0;
      stage     <= '0;
      scratch_o <= '0;
      led_o     <= '0;
      tick      <= '0;
      snap      <= '0;
      wrCount   <= '0;
      xoReg     <= '0;
    end else begin
      prevAddr <= xi.xi_prwa;
      wsub     <= wsubNext;
      tick     <= tick + 24'd1;
      wrCount  <= wrCountNext;
      xoReg    <= xoNext;
      if (xi.xi_pwr) begin
        if (xi.xi_prwa == ADDR_SCRATCH) begin
          // Sub 1 commits the pair, pairing the earlier staged half with this data.
          if (effSub == SUB0) begin
            stage <= xi.xi_pd;
          end else if (effSub == SUB1) begin
            scratch_o <= {stage, xi.xi_pd};
          end
        end
        if ((xi.xi_prwa == ADDR_LED) && (effSub == SUB0)) begin
          led_o <= xi.xi_pd;
        end
        if (xi.xi_prwa == ADDR_TICK) begin
          snap <= tick;
        end
      end
    end
  end

  assign xi.xo = xoReg;

endmodule

// File: tb/tb_pif_xi_regbank.sv
// Self-checking bench for pif_xi_regbank: directed scenarios plus randomized traffic,
// all checked against an integer-level reference model of the register map.
module tb_pif_xi_regbank;

  logic        xclk = 1'b0;
  logic        rst;
  logic [5:0]  led_o;
  logic [11:0] scratch_o;

  pif_xi_if #(.XA_BITS(4), .DATA_BITS(6), .SUBA_BITS(3)) bus ();

  pif_xi_regbank #(
    .XA_BITS(4), .DATA_BITS(6), .SUBA_BITS(3), .ID_STRING(64'h5049_4620_7631_2E30)
  ) dut (
    .xclk(xclk),
    .rst(rst),
    .xi(bus),
    .led_o(led_o),
    .scratch_o(scratch_o)
  );

  always #5 xclk = ~xclk;

  int nCmp = 0;
  int nBad = 0;

  // Reference model state, plain integers
  int mdlPrev, mdlWsub, mdlStage, mdlScratch, mdlLed, mdlTick, mdlSnap, mdlWr, mdlXo;

  function automatic int mdlRead(int addr, int sub);
    logic [63:0] id;
    id = 64'h5049_4620_7631_2E30;
    case (addr)
      0: return (sub < 8) ? int'((id >> (8 * (7 - sub))) & 64'hFF) : 0;
      1: return (sub == 0) ? mdlScratch / 256 : (sub == 1) ? mdlScratch % 256 : 0;
      2: return (sub == 0) ? mdlLed : 0;
      3: return (sub == 0) ? mdlSnap / 65536 : (sub == 1) ? (mdlSnap / 256) % 256 :
                (sub == 2) ? mdlSnap % 256 : 0;
      4: return (sub == 0) ? mdlWr : 0;
      default: return 0;
    endcase
  endfunction

  // One clock: drive inputs, advance the model across the edge, sample 1 ns after it.
  task automatic cycle(input bit r, input int addr, input bit pwr, input int pd,
                       input bit fin, input int rsub);
    int chg;
    int sub;
    rst               = r;
    bus.xi_prwa       = 4'(addr);
    bus.xi_pwr        = pwr;
    bus.xi_pd         = 6'(pd);
    bus.xi_prdfinished = fin;
    bus.xi_prdsuba    = 3'(rsub);
    if (r) begin
      mdlPrev = 0; mdlWsub = 0; mdlStage = 0; mdlScratch = 0; mdlLed = 0;
      mdlTick = 0; mdlSnap = 0; mdlWr = 0; mdlXo = 0;
    end else begin
      mdlXo = mdlRead(addr, rsub);
      chg   = (addr != mdlPrev) ? 1 : 0;
      sub   = chg ? 0 : mdlWsub;
      if (pwr) begin
        if (addr == 1 && sub == 0) mdlStage = pd;
        if (addr == 1 && sub == 1) mdlScratch = mdlStage * 64 + pd;
        if (addr == 2 && sub == 0) mdlLed = pd;
        if (addr == 3) mdlSnap = mdlTick;
        mdlWsub = chg ? 1 : ((mdlWsub < 7) ? mdlWsub + 1 : 7);
      end else if (chg) begin
        mdlWsub = 0;
      end
      if (fin && addr == 4 && rsub == 0) mdlWr = pwr ? 1 : 0;
      else if (pwr && mdlWr < 255) mdlWr = mdlWr + 1;
      mdlTick = (mdlTick + 1) % (1 << 24);
      mdlPrev = addr;
    end
    @(posedge xclk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    nCmp++; if (bus.xo !== 8'h00) begin nBad++; $display("FAIL reset_xo: got %h want 00", bus.xo); end
    nCmp++; if (led_o !== 6'h00) begin nBad++; $display("FAIL reset_led: got %h want 00", led_o); end
    nCmp++; if (scratch_o !== 12'h000) begin nBad++; $display("FAIL reset_scratch: got %h want 000", scratch_o); end
    $display("reset: xo=%h led=%h scratch=%h", bus.xo, led_o, scratch_o);
  endtask

  task automatic test_id();
    logic [7:0] idBytes [8];
    idBytes = '{8'h50, 8'h49, 8'h46, 8'h20, 8'h76, 8'h31, 8'h2E, 8'h30};
    for (int s = 0; s < 8; s++) begin
      cycle(0, 0, 0, 0, 0, s);
      nCmp++;
      if (bus.xo !== idBytes[s] || bus.xo !== 8'(mdlXo)) begin
        nBad++; $display("FAIL id_sub%0d: got %h want %h", s, bus.xo, idBytes[s]);
      end
      $display("id sub%0d: xo=%h", s, bus.xo);
    end
  endtask

  task automatic test_scratch();
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 6'h2A, 0, 0);
    nCmp++; if (scratch_o !== 12'h000) begin nBad++; $display("FAIL scratch_stage_only: got %h want 000", scratch_o); end
    cycle(0, 1, 1, 6'h15, 0, 0);
    nCmp++; if (scratch_o !== 12'hA95) begin nBad++; $display("FAIL scratch_commit: got %h want a95", scratch_o); end
    cycle(0, 1, 0, 0, 0, 0);
    nCmp++; if (bus.xo !== 8'h0A || bus.xo !== 8'(mdlXo)) begin nBad++; $display("FAIL scratch_rd0: got %h want 0a", bus.xo); end
    cycle(0, 1, 0, 0, 0, 1);
    nCmp++; if (bus.xo !== 8'h95 || bus.xo !== 8'(mdlXo)) begin nBad++; $display("FAIL scratch_rd1: got %h want 95", bus.xo); end
    $display("scratch: scratch_o=%h xo=%h", scratch_o, bus.xo);
  endtask

  task automatic test_back_to_back();
    cycle(0, 2, 0, 0, 0, 0);
    cycle(0, 2, 1, 6'h3F, 0, 0);
    cycle(0, 2, 1, 6'h11, 0, 0);
    cycle(0, 2, 1, 6'h00, 0, 0);
    nCmp++; if (led_o !== 6'h3F || led_o !== 6'(mdlLed)) begin nBad++; $display("FAIL led_burst: got %h want 3f", led_o); end
    cycle(0, 2, 0, 0, 0, 0);
    nCmp++; if (bus.xo !== 8'h3F) begin nBad++; $display("FAIL led_read: got %h want 3f", bus.xo); end
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 2, 1, 6'h01, 0, 0);
    nCmp++; if (led_o !== 6'h01) begin nBad++; $display("FAIL led_addrchg_write: got %h want 01", led_o); end
    $display("led: led_o=%h", led_o);
  endtask

  task automatic test_tick();
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 3, 1, 6'h2B, 0, 0);
    for (int s = 0; s < 4; s++) begin
      cycle(0, 3, 0, 0, 0, s);
      nCmp++; if (bus.xo !== 8'(mdlXo)) begin nBad++; $display("FAIL snap_sub%0d: got %h want %h", s, bus.xo, 8'(mdlXo)); end
      $display("tick snap sub%0d: xo=%h", s, bus.xo);
    end
    force dut.tick = 24'hFFFFFE;
    #1;
    release dut.tick;
    mdlTick = 24'hFFFFFE;
    cycle(0, 3, 0, 0, 0, 0);
    cycle(0, 3, 1, 0, 0, 0);
    cycle(0, 3, 0, 0, 0, 2);
    cycle(0, 3, 0, 0, 0, 0);
    nCmp++; if (bus.xo !== 8'hFF || bus.xo !== 8'(mdlXo)) begin nBad++; $display("FAIL snap_top: got %h want ff", bus.xo); end
    cycle(0, 3, 1, 0, 0, 0);
    cycle(0, 3, 0, 0, 0, 2);
    cycle(0, 3, 0, 0, 0, 2);
    nCmp++; if (bus.xo !== 8'(mdlXo)) begin nBad++; $display("FAIL snap_wrap: got %h want %h", bus.xo, 8'(mdlXo)); end
    $display("tick wrap: snap lo=%h", bus.xo);
  endtask

  task automatic test_wrcount();
    for (int i = 0; i < 300; i++) cycle(0, 5, 1, int'($urandom_range(0, 63)), 0, 0);
    cycle(0, 4, 0, 0, 0, 0);
    nCmp++; if (bus.xo !== 8'hFF) begin nBad++; $display("FAIL wrcount_sat: got %h want ff", bus.xo); end
    cycle(0, 4, 1, 0, 1, 0);
    cycle(0, 4, 0, 0, 0, 0);
    nCmp++; if (bus.xo !== 8'h01) begin nBad++; $display("FAIL wrcount_clr_pwr: got %h want 01", bus.xo); end
    cycle(0, 4, 0, 0, 1, 0);
    cycle(0, 4, 0, 0, 0, 0);
    nCmp++; if (bus.xo !== 8'h00) begin nBad++; $display("FAIL wrcount_clr: got %h want 00", bus.xo); end
    $display("wrcount: xo=%h", bus.xo);
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 6'h2A, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    nCmp++; if (bus.xo !== 8'h00) begin nBad++; $display("FAIL rstmid_rd0: got %h want 00", bus.xo); end
    cycle(0, 1, 1, 6'h15, 0, 0);
    nCmp++; if (scratch_o !== 12'h000) begin nBad++; $display("FAIL rstmid_stage_only: got %h want 000", scratch_o); end
    cycle(0, 1, 1, 6'h00, 0, 0);
    nCmp++; if (scratch_o !== 12'h540) begin nBad++; $display("FAIL rstmid_commit: got %h want 540", scratch_o); end
    $display("reset mid-sequence: scratch_o=%h", scratch_o);
  endtask

  task automatic test_random();
    int addr;
    addr = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        addr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 15)) : int'($urandom_range(0, 5));
      end
      cycle($urandom_range(0, 149) == 0, addr, $urandom_range(0, 1) == 1, int'($urandom_range(0, 63)),
            $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)));
      nCmp++; if (bus.xo !== 8'(mdlXo)) begin nBad++; $display("FAIL rand_xo[%0d]: got %h want %h", i, bus.xo, 8'(mdlXo)); end
      nCmp++; if (led_o !== 6'(mdlLed)) begin nBad++; $display("FAIL rand_led[%0d]: got %h want %h", i, led_o, 6'(mdlLed)); end
      nCmp++; if (scratch_o !== 12'(mdlScratch)) begin nBad++; $display("FAIL rand_scratch[%0d]: got %h want %h", i, scratch_o, 12'(mdlScratch)); end
    end
    $display("random: 600 cycles, a=%0d xo=%h", addr, bus.xo);
  endtask

  initial begin
    test_reset();
    test_id();
    test_scratch();
    test_back_to_back();
    test_tick();
    test_wrcount();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
